// File: rtl/cdb_tag_arbiter.sv
// Round-robin arbiter that puts one functional-unit result per cycle on the CDB
// and tracks which tags are outstanding between dispatch and writeback.
module cdb_tag_arbiter #(
  parameter int NUM_FU = 4,
  parameter int TAG_W  = 6,
  parameter int DATA_W = 32
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [NUM_FU-1:0]          fu_req,
  input  logic [NUM_FU*TAG_W-1:0]    fu_tag,
  input  logic [NUM_FU*DATA_W-1:0]   fu_data,
  output logic [NUM_FU-1:0]          fu_grant,
  input  logic                       tf_full,
  input  logic                       alloc_valid,
  input  logic [TAG_W-1:0]           alloc_tag,
  output logic [TAG_W-1:0]           cdb_tag,
  output logic [DATA_W-1:0]          cdb_data,
  output logic                       cdb_valid,
  output logic [TAG_W:0]             out_cnt,
  output logic                       dup_err,
  output logic                       alloc_err
);

  localparam int PTR_W    = (NUM_FU > 1) ? $clog2(NUM_FU) : 1;
  localparam int NUM_TAGS = 2 ** TAG_W;
  localparam logic [PTR_W:0] FU_CNT  = (PTR_W+1)'(NUM_FU);
  localparam logic [TAG_W:0] CNT_MAX = (TAG_W+1)'(NUM_TAGS);

  // Saturating outstanding-tag counter; simultaneous alloc and grant cancel out.
  function automatic logic [TAG_W:0] sat_cnt(input logic [TAG_W:0] cnt,
                                             input logic inc, input logic dec);
    logic [TAG_W:0] res;
    res = cnt;
    if (inc && !dec && cnt != CNT_MAX) res = cnt + 1'b1;
    else if (dec && !inc && cnt != '0) res = cnt - 1'b1;
    return res;
  endfunction

  logic [PTR_W-1:0]    rr_ptr;
  logic [NUM_TAGS-1:0] sb;
  logic [TAG_W-1:0]    tag_arr  [NUM_FU];
  logic [DATA_W-1:0]   data_arr [NUM_FU];

  logic                gnt_vld_p0;
  logic [PTR_W-1:0]    gnt_idx_p0;
  logic [NUM_FU-1:0]   gnt_vec_p0;
  logic [TAG_W-1:0]    gnt_tag_p0;
  logic [DATA_W-1:0]   gnt_data_p0;
  logic [PTR_W:0]      pos_p0;
  logic [PTR_W:0]      nxt_p0;
  logic                found_p0;
  logic [NUM_TAGS-1:0] sb_set_p0;
  logic [NUM_TAGS-1:0] sb_clr_p0;
  logic                dup_hit_p0;
  logic                alloc_hit_p0;

  always_comb begin
    for (int i = 0; i < NUM_FU; i++) begin
      tag_arr[i]  = fu_tag[i*TAG_W +: TAG_W];
      data_arr[i] = fu_data[i*DATA_W +: DATA_W];
    end
  end

  // Stage p0: combinational round-robin search starting at rr_ptr.
  always_comb begin
    found_p0   = 1'b0;
    gnt_idx_p0 = '0;
    pos_p0     = '0;
    for (int k = 0; k < NUM_FU; k++) begin
      pos_p0 = {1'b0, rr_ptr} + (PTR_W+1)'(k);
      if (pos_p0 >= FU_CNT) pos_p0 = pos_p0 - FU_CNT;
      if (!found_p0 && fu_req[pos_p0[PTR_W-1:0]]) begin
        found_p0   = 1'b1;
        gnt_idx_p0 = pos_p0[PTR_W-1:0];
      end
    end
    gnt_vld_p0 = found_p0 && !tf_full && !rst;
    gnt_vec_p0 = '0;
    if (gnt_vld_p0) gnt_vec_p0[gnt_idx_p0] = 1'b1;
    gnt_tag_p0  = tag_arr[gnt_idx_p0];
    gnt_data_p0 = data_arr[gnt_idx_p0];
    nxt_p0 = {1'b0, gnt_idx_p0} + 1'b1;
    if (nxt_p0 >= FU_CNT) nxt_p0 = '0;
    sb_set_p0 = '0;
    sb_clr_p0 = '0;
    if (alloc_valid) sb_set_p0[alloc_tag] = 1'b1;
    if (gnt_vld_p0)  sb_clr_p0[gnt_tag_p0] = 1'b1;
    // Both error checks look at the scoreboard as it stands before this cycle's update.
    dup_hit_p0   = gnt_vld_p0 && !sb[gnt_tag_p0];
    alloc_hit_p0 = alloc_valid && sb[alloc_tag];
  end

  assign fu_grant = gnt_vec_p0;

  // Stage p1: broadcast register and scoreboard state.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cdb_valid <= 1'b0;
      cdb_tag   <= '0;
      cdb_data  <= '0;
      rr_ptr    <= '0;
      sb        <= '0;
      out_cnt   <= '0;
      dup_err   <= 1'b0;
      alloc_err <= 1'b0;
    end else begin
      cdb_valid <= gnt_vld_p0;
      if (gnt_vld_p0) begin
        cdb_tag  <= gnt_tag_p0;
        cdb_data <= gnt_data_p0;
        rr_ptr   <= nxt_p0[PTR_W-1:0];
      end
      sb        <= (sb & ~sb_clr_p0) | sb_set_p0;
      out_cnt   <= sat_cnt(out_cnt, alloc_valid, gnt_vld_p0);
      dup_err   <= dup_err | dup_hit_p0;
      alloc_err <= alloc_err | alloc_hit_p0;
    end
  end

endmodule

// File: tb/tb_cdb_tag_arbiter.sv
// Directed bench for cdb_tag_arbiter: grant checked in-cycle, CDB output checked
// one cycle later against a queue of expected broadcasts.
module tb_cdb_tag_arbiter;

  logic         clk = 1'b0;
  logic         rst;
  logic [3:0]   fu_req;
  logic [23:0]  fu_tag;
  logic [127:0] fu_data;
  logic [3:0]   fu_grant;
  logic         tf_full;
  logic         alloc_valid;
  logic [5:0]   alloc_tag;
  logic [5:0]   cdb_tag;
  logic [31:0]  cdb_data;
  logic         cdb_valid;
  logic [6:0]   out_cnt;
  logic         dup_err;
  logic         alloc_err;

  cdb_tag_arbiter #(.NUM_FU(4), .TAG_W(6), .DATA_W(32)) dut (
    .clk(clk), .rst(rst), .fu_req(fu_req), .fu_tag(fu_tag), .fu_data(fu_data),
    .fu_grant(fu_grant), .tf_full(tf_full), .alloc_valid(alloc_valid),
    .alloc_tag(alloc_tag), .cdb_tag(cdb_tag), .cdb_data(cdb_data),
    .cdb_valid(cdb_valid), .out_cnt(out_cnt), .dup_err(dup_err), .alloc_err(alloc_err)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic        v;
    logic [5:0]  t;
    logic [31:0] d;
  } exp_t;

  exp_t        exp_q[$];
  logic [5:0]  last_tag;
  logic [31:0] last_data;
  int          checks;
  int          failures;

  task automatic chk(input string nm, input logic [63:0] obs, input logic [63:0] expv);
    checks++;
    assert (obs === expv) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", nm, obs, expv);
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    fu_req = '0; alloc_valid = 1'b0; tf_full = 1'b0;
    #1;
    @(posedge clk); #1;
    rst = 1'b0;
    last_tag = '0;
    last_data = '0;
  endtask

  // One clock of stimulus: grant checked before the edge, broadcast after it.
  task automatic step(input string nm, input logic [3:0] req, input logic [23:0] tags,
                      input logic [127:0] datas, input logic full, input logic av,
                      input logic [5:0] at, input logic [3:0] exp_g);
    exp_t e;
    fu_req = req; fu_tag = tags; fu_data = datas;
    tf_full = full; alloc_valid = av; alloc_tag = at;
    #1;
    chk({nm, ".grant"}, 64'(fu_grant), 64'(exp_g));
    for (int i = 0; i < 4; i++)
      if (exp_g[i]) begin
        last_tag  = tags[i*6 +: 6];
        last_data = datas[i*32 +: 32];
      end
    e.v = (exp_g != 4'd0);
    e.t = last_tag;
    e.d = last_data;
    exp_q.push_back(e);
    @(posedge clk); #1;
    fu_req = '0; alloc_valid = 1'b0;
    if (exp_q.size() == 0) begin
      checks++; failures++;
      $error("FAIL %s.queue observed=empty expected=entry", nm);
    end else begin
      e = exp_q.pop_front();
      chk({nm, ".cdb_valid"}, 64'(cdb_valid), 64'(e.v));
      chk({nm, ".cdb_tag"},   64'(cdb_tag),   64'(e.t));
      chk({nm, ".cdb_data"},  64'(cdb_data),  64'(e.d));
    end
  endtask

  initial begin
    checks = 0; failures = 0;
    rst = 1'b1; fu_req = 4'hF; fu_tag = '0; fu_data = '0;
    tf_full = 1'b0; alloc_valid = 1'b0; alloc_tag = '0;
    last_tag = '0; last_data = '0;
    #2;
    chk("rst.grant", 64'(fu_grant), 64'd0);
    @(posedge clk); #1;
    chk("rst.cdb_valid", 64'(cdb_valid), 64'd0);
    chk("rst.cdb_tag",   64'(cdb_tag),   64'd0);
    chk("rst.cdb_data",  64'(cdb_data),  64'd0);
    chk("rst.out_cnt",   64'(out_cnt),   64'd0);
    chk("rst.dup_err",   64'(dup_err),   64'd0);
    chk("rst.alloc_err", 64'(alloc_err), 64'd0);
    do_reset();

    // Single request
    step("single.alloc", 4'b0000, '0, '0, 1'b0, 1'b1, 6'd5, 4'b0000);
    chk("single.cnt1", 64'(out_cnt), 64'd1);
    step("single.req", 4'b0001, {18'd0, 6'd5}, {96'd0, 32'hDEAD}, 1'b0, 1'b0, 6'd0, 4'b0001);
    chk("single.cnt0", 64'(out_cnt), 64'd0);
    chk("single.dup", 64'(dup_err), 64'd0);
    chk("single.aerr", 64'(alloc_err), 64'd0);

    // Round robin from pointer 0
    do_reset();
    for (int t = 1; t <= 4; t++)
      step("rr.alloc", 4'b0000, '0, '0, 1'b0, 1'b1, 6'(t), 4'b0000);
    chk("rr.cnt4", 64'(out_cnt), 64'd4);
    step("rr.g0", 4'b1111, {6'd4, 6'd3, 6'd2, 6'd1}, {32'h103, 32'h102, 32'h101, 32'h100}, 1'b0, 1'b0, 6'd0, 4'b0001);
    step("rr.g1", 4'b1110, {6'd4, 6'd3, 6'd2, 6'd1}, {32'h103, 32'h102, 32'h101, 32'h100}, 1'b0, 1'b0, 6'd0, 4'b0010);
    step("rr.g2", 4'b1100, {6'd4, 6'd3, 6'd2, 6'd1}, {32'h103, 32'h102, 32'h101, 32'h100}, 1'b0, 1'b0, 6'd0, 4'b0100);
    step("rr.g3", 4'b1000, {6'd4, 6'd3, 6'd2, 6'd1}, {32'h103, 32'h102, 32'h101, 32'h100}, 1'b0, 1'b0, 6'd0, 4'b1000);
    chk("rr.cnt0", 64'(out_cnt), 64'd0);
    step("rr.idle_hold", 4'b0000, '0, '0, 1'b0, 1'b0, 6'd0, 4'b0000);

    // Full stall: unit 1 waits, tag 10 allocated meanwhile
    step("stall.1", 4'b0010, {12'd0, 6'd10, 6'd0}, {32'd0, 32'd0, 32'hBEEF, 32'd0}, 1'b1, 1'b1, 6'd10, 4'b0000);
    step("stall.2", 4'b0010, {12'd0, 6'd10, 6'd0}, {32'd0, 32'd0, 32'hBEEF, 32'd0}, 1'b1, 1'b0, 6'd0, 4'b0000);
    step("stall.3", 4'b0010, {12'd0, 6'd10, 6'd0}, {32'd0, 32'd0, 32'hBEEF, 32'd0}, 1'b1, 1'b0, 6'd0, 4'b0000);
    chk("stall.cnt", 64'(out_cnt), 64'd1);
    step("stall.release", 4'b0010, {12'd0, 6'd10, 6'd0}, {32'd0, 32'd0, 32'hBEEF, 32'd0}, 1'b0, 1'b0, 6'd0, 4'b0010);
    chk("stall.cnt0", 64'(out_cnt), 64'd0);
    chk("stall.dup", 64'(dup_err), 64'd0);

    // Duplicate return of never-allocated tag 9 (pointer now 2)
    step("dup.g", 4'b0100, {6'd0, 6'd9, 12'd0}, {32'd0, 32'h99, 64'd0}, 1'b0, 1'b0, 6'd0, 4'b0100);
    chk("dup.err", 64'(dup_err), 64'd1);
    chk("dup.cnt_sat0", 64'(out_cnt), 64'd0);
    step("dup.idle", 4'b0000, '0, '0, 1'b0, 1'b0, 6'd0, 4'b0000);
    chk("dup.sticky", 64'(dup_err), 64'd1);

    // Same-cycle alloc and grant of outstanding tag 7
    do_reset();
    step("same.alloc", 4'b0000, '0, '0, 1'b0, 1'b1, 6'd7, 4'b0000);
    step("same.both", 4'b0001, {18'd0, 6'd7}, {96'd0, 32'h77}, 1'b0, 1'b1, 6'd7, 4'b0001);
    chk("same.aerr", 64'(alloc_err), 64'd1);
    chk("same.cnt", 64'(out_cnt), 64'd1);
    chk("same.dup", 64'(dup_err), 64'd0);
    step("same.regrant", 4'b0010, {12'd0, 6'd7, 6'd0}, {64'd0, 32'h78, 32'd0}, 1'b0, 1'b0, 6'd0, 4'b0010);
    chk("same.sb_bit7", 64'(dup_err), 64'd0);
    chk("same.cnt0", 64'(out_cnt), 64'd0);
    chk("same.aerr_sticky", 64'(alloc_err), 64'd1);

    // Mid-run reset during a 1111 burst (pointer now 2)
    step("mid.g", 4'b1111, {6'd4, 6'd3, 6'd2, 6'd1}, {32'h203, 32'h202, 32'h201, 32'h200}, 1'b0, 1'b1, 6'd20, 4'b0100);
    fu_req = 4'b1111;
    rst = 1'b1;
    #1;
    chk("mid.grant", 64'(fu_grant), 64'd0);
    chk("mid.cdb_valid", 64'(cdb_valid), 64'd0);
    chk("mid.cdb_tag", 64'(cdb_tag), 64'd0);
    chk("mid.cdb_data", 64'(cdb_data), 64'd0);
    chk("mid.cnt", 64'(out_cnt), 64'd0);
    chk("mid.aerr", 64'(alloc_err), 64'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    last_tag = '0; last_data = '0;
    chk("mid.post_valid", 64'(cdb_valid), 64'd0);
    step("mid.first", 4'b1111, {6'd4, 6'd3, 6'd2, 6'd1}, {32'h203, 32'h202, 32'h201, 32'h200}, 1'b0, 1'b0, 6'd0, 4'b0001);
    chk("mid.dup_after", 64'(dup_err), 64'd1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #50000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/cdb_tag_arbiter.md
CDB_TAG_ARBITER -- requirements
Module: cdb_tag_arbiter

Interface
REQ-001 SHALL have parameter NUM_FU, default 4, the number of requesting functional units.
REQ-002 SHALL have parameter TAG_W, default 6, the tag width (64 tags).
REQ-003 SHALL have parameter DATA_W, default 32, the result data width.
REQ-004 SHALL have port clk, input, 1, the single clock.
REQ-005 SHALL have port rst, input, 1, reset: asynchronous and active-high.
REQ-006 SHALL have port fu_req, input, NUM_FU, per-unit completion request.
REQ-007 SHALL have port fu_tag, input, NUM_FU*TAG_W, per-unit tag; unit i occupies bits [i*TAG_W +: TAG_W].
REQ-008 SHALL have port fu_data, input, NUM_FU*DATA_W, per-unit result, packed the same way as fu_tag.
REQ-009 SHALL have port fu_grant, output, NUM_FU, one-hot grant, combinational.
REQ-010 SHALL have port tf_full, input, 1, tag FIFO full flag.
REQ-011 SHALL have port alloc_valid, input, 1, dispatcher took a tag from the tag FIFO this cycle.
REQ-012 SHALL have port alloc_tag, input, TAG_W, the tag taken.
REQ-013 SHALL have port cdb_tag, output, TAG_W, broadcast tag; drives the tag FIFO write data.
REQ-014 SHALL have port cdb_data, output, DATA_W, broadcast result.
REQ-015 SHALL have port cdb_valid, output, 1, broadcast valid; drives the tag FIFO write enable.
REQ-016 SHALL have port out_cnt, output, TAG_W+1, number of outstanding tags.
REQ-017 SHALL have port dup_err, output, 1, sticky: a tag was broadcast that was not outstanding.
REQ-018 SHALL have port alloc_err, output, 1, sticky: an already-outstanding tag was allocated.

Function
REQ-019 SHALL assert at most one fu_grant bit per cycle; a grant is issued only when tf_full=0 and at least one fu_req bit is 1.
REQ-020 SHALL select the unit round-robin: search from pointer rr_ptr upward modulo NUM_FU, and grant the first requesting unit.
REQ-021 SHALL update rr_ptr to (granted index + 1) mod NUM_FU on a grant; rr_ptr holds when there is no grant.
REQ-022 SHALL register the granted unit's tag and data into cdb_tag/cdb_data and set cdb_valid=1 on the next clock edge (latency 1).
REQ-023 SHALL set cdb_valid=0 and hold cdb_tag/cdb_data in any cycle following a no-grant cycle.
REQ-024 SHALL keep the handshake as follows: a unit holds fu_req, fu_tag and fu_data stable until it is granted, and drops fu_req or presents a new result in the cycle after the grant.
REQ-025 SHALL issue no grant while tf_full=1; pending requests wait and no state other than the scoreboard changes.
REQ-026 SHALL maintain an outstanding scoreboard with one bit per tag (2^TAG_W bits): alloc_valid sets bit alloc_tag, and a grant clears bit of the granted tag.
REQ-027 SHALL update the scoreboard as next = (sb & ~clear) | set, with both error checks evaluated against the current sb.
REQ-028 SHALL set dup_err when a granted tag's scoreboard bit is 0.
REQ-029 SHALL set alloc_err when alloc_valid=1 and the alloc_tag bit is 1, including when the same tag is granted in the same cycle.
REQ-030 SHALL keep dup_err and alloc_err set until reset once asserted.
REQ-031 SHALL update out_cnt as follows: +1 on alloc only, -1 on grant only, unchanged on both or neither, saturating at 0 and 2^TAG_W.

Reset
REQ-032 SHALL, while rst=1, asynchronously clear cdb_valid, cdb_tag, cdb_data, rr_ptr, the scoreboard, out_cnt, dup_err and alloc_err to 0.
REQ-033 SHALL force fu_grant to 0 while rst=1.
REQ-034 SHALL discard any grant in flight when rst is asserted mid-operation, so cdb_valid is 0 on the first cycle after release.

Verification
REQ-035 SHALL cover single request: alloc tag 5, then fu_req=0001 with tag 5, data 0xDEAD -> fu_grant=0001 the same cycle; the next cycle gives cdb_valid=1, cdb_tag=5, cdb_data=0xDEAD, out_cnt 1->0, no error.
REQ-036 SHALL cover round-robin: tags 1-4 allocated, fu_req=1111 held with each unit dropping after its grant -> grants 0001, 0010, 0100, 1000 on consecutive cycles; cdb_valid stays high for 4 cycles.
REQ-037 SHALL cover full stall: tf_full=1 with fu_req=0010 for 3 cycles -> fu_grant=0 and cdb_valid=0 throughout; on the cycle tf_full falls, grant is 0010.
REQ-038 SHALL cover duplicate return: grant tag 9, which was never allocated -> cdb_valid=1 with cdb_tag=9 the next cycle, and dup_err=1 and stays 1.
REQ-039 SHALL cover same-cycle alloc and grant of tag 7 (outstanding) -> alloc_err=1, scoreboard bit 7 ends at 1, out_cnt unchanged.
REQ-040 SHALL cover mid-run reset: rst pulsed during a 1111 burst -> all outputs are 0 immediately, and the first grant after release goes to unit 0.
